// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: grants change only at burst boundaries, and a
// master holding HLOCK keeps the bus until it releases the lock.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic [3:0]             HMASTER_DATA,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BU_INCR   = 3'd1;
  localparam logic [3:0] DEF_IDX   = 4'(DEFAULT_MASTER);

  typedef enum logic [1:0] {ST_OPEN, ST_BURST, ST_LOCKED} state_t;

  function automatic logic [3:0] burst_len_m1(input logic [2:0] burst);
    case (burst)
      3'd0, 3'd1: burst_len_m1 = 4'd0;
      3'd2, 3'd3: burst_len_m1 = 4'd3;
      3'd4, 3'd5: burst_len_m1 = 4'd7;
      default:    burst_len_m1 = 4'd15;
    endcase
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [3:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      onehot[i] = (idx == 4'(i));
    end
  endfunction

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic [3:0]             r_master;
  logic [3:0]             r_master_data;
  logic [NUM_MASTERS-1:0] r_grant;
  logic                   r_mastlock;

  logic [3:0]  w_len_m1;
  logic        w_last;
  logic [15:0] w_req_ext;
  logic [15:0] w_lock_ext;
  logic [4:0]  w_idx;
  logic        w_found;
  logic [3:0]  w_rr;
  logic [3:0]  w_winner;

  // SEQ of an undefined-length INCR burst is re-arbitrable on every beat.
  always_comb begin
    w_len_m1 = burst_len_m1(HBURST);
    case (HTRANS)
      TR_IDLE:   w_last = 1'b1;
      TR_NONSEQ: w_last = (w_len_m1 == 4'd0);
      TR_SEQ:    w_last = (r_cnt <= 4'd1) || (HBURST == BU_INCR);
      default:   w_last = 1'b0;
    endcase
  end

  // Search starts just after the owner and wraps, so the owner ranks last.
  always_comb begin
    w_req_ext  = 16'(HBUSREQ);
    w_lock_ext = 16'(HLOCK);
    w_rr       = DEF_IDX;
    w_found    = 1'b0;
    w_idx      = 5'd0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_idx = {1'b0, r_master} + 5'(i);
      if (w_idx >= 5'(NUM_MASTERS)) begin
        w_idx = w_idx - 5'(NUM_MASTERS);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && w_req_ext[w_idx[3:0]]) begin
        w_rr    = w_idx[3:0];
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    if (w_lock_ext[r_master]) begin
      w_winner = r_master;
    end else begin
      w_winner = w_rr;
    end
  end

  // Beat counter, arbitration FSM and registered bus-select outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state       <= ST_OPEN;
      r_cnt         <= 4'd0;
      r_master      <= DEF_IDX;
      r_master_data <= DEF_IDX;
      r_grant       <= onehot(DEF_IDX);
      r_mastlock    <= 1'b0;
    end else if (HREADY) begin
      r_master_data <= r_master;
      case (HTRANS)
        TR_NONSEQ: r_cnt <= w_len_m1;
        TR_SEQ:    r_cnt <= (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
        TR_IDLE:   r_cnt <= 4'd0;
        default:   r_cnt <= r_cnt;
      endcase
      if (w_last) begin
        r_master   <= w_winner;
        r_grant    <= onehot(w_winner);
        r_mastlock <= w_lock_ext[w_winner];
        r_state    <= w_lock_ext[w_winner] ? ST_LOCKED : ST_OPEN;
      end else if (HTRANS == TR_NONSEQ && r_state == ST_OPEN) begin
        r_state <= ST_BURST;
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign HGRANT       = r_grant;
  assign HMASTER      = r_master;
  assign HMASTER_DATA = r_master_data;
  assign HMASTLOCK    = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_ahb_arbiter;
  localparam int N = 3;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [N-1:0] HBUSREQ, HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic [N-1:0] HGRANT;
  logic [3:0]   HMASTER, HMASTER_DATA;
  logic         HMASTLOCK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: bus owner, data owner, lock flag, burst progress.
  int m_owner, m_data, m_blen, m_done;
  bit m_lock;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT),
    .HMASTER(HMASTER), .HMASTER_DATA(HMASTER_DATA), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  function automatic int beats_of(input int b);
    case (b)
      0, 1:    return 1;
      2, 3:    return 4;
      4, 5:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic void model_reset();
    m_owner = 0; m_data = 0; m_lock = 0; m_blen = 0; m_done = 0;
  endfunction

  function automatic void model_step();
    bit last;
    int win;
    if (!HREADY) return;
    case (HTRANS)
      2'd0:    last = 1;
      2'd2:    last = (beats_of(HBURST) == 1);
      2'd3:    last = ((m_blen - m_done) <= 1) || (HBURST == 3'd1);
      default: last = 0;
    endcase
    case (HTRANS)
      2'd0: begin m_blen = 0; m_done = 0; end
      2'd2: begin m_blen = beats_of(HBURST); m_done = 1; end
      2'd3: if (m_done < m_blen) m_done++;
      default: ;
    endcase
    m_data = m_owner;
    if (last) begin
      if (HLOCK[m_owner]) win = m_owner;
      else begin
        win = 0;
        for (int k = 1; k <= N; k++) begin
          if (HBUSREQ[(m_owner + k) % N]) begin win = (m_owner + k) % N; break; end
        end
      end
      m_lock  = HLOCK[win];
      m_owner = win;
    end
  endfunction

  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    HBUSREQ = req; HLOCK = lck; HTRANS = tr; HBURST = bu; HREADY = rdy;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    drive(3'b000, 3'b000, 2'd0, 3'd0, 1'b1);
    model_reset();
    @(posedge HCLK); #1;
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b0;
    drive(3'b111, 3'b000, 2'd0, 3'd0, 1'b1);
    #3 HRESET = 1'b1;
    #1;
    n_checks++; if (HGRANT !== 3'b001) $display("FAIL reset_grant got %b want 001", HGRANT); else n_pass++;
    n_checks++; if (HMASTER !== 4'd0) $display("FAIL reset_master got %0d want 0", HMASTER); else n_pass++;
    n_checks++; if (HMASTLOCK !== 1'b0) $display("FAIL reset_mastlock got %b want 0", HMASTLOCK); else n_pass++;
    n_checks++; if (HMASTER_DATA !== 4'd0) $display("FAIL reset_mdata got %0d want 0", HMASTER_DATA); else n_pass++;
    @(posedge HCLK); #1;
    n_checks++; if (HGRANT !== 3'b001) $display("FAIL reset_hold_grant got %b want 001", HGRANT); else n_pass++;
    HRESET = 1'b0;
    model_reset();
    tick();
    n_checks++; if (HMASTER !== 4'd1) $display("FAIL reset_first_arb got %0d want 1", HMASTER); else n_pass++;
    n_checks++; if (HGRANT !== 3'b010) $display("FAIL reset_first_grant got %b want 010", HGRANT); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_m [4] = '{4'd1, 4'd2, 4'd0, 4'd1};
    logic [3:0] exp_d [4] = '{4'd0, 4'd1, 4'd2, 4'd0};
    logic [2:0] g;
    do_reset();
    drive(3'b111, 3'b000, 2'd0, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      g = 3'b001 << exp_m[i];
      n_checks++; if (HMASTER !== exp_m[i]) $display("FAIL rr_master[%0d] got %0d want %0d", i, HMASTER, exp_m[i]); else n_pass++;
      n_checks++; if (HGRANT !== g) $display("FAIL rr_grant[%0d] got %b want %b", i, HGRANT, g); else n_pass++;
      n_checks++; if (HMASTER_DATA !== exp_d[i]) $display("FAIL rr_mdata[%0d] got %0d want %0d", i, HMASTER_DATA, exp_d[i]); else n_pass++;
    end
  endtask

  task automatic test_incr4_hold();
    do_reset();
    drive(3'b101, 3'b000, 2'd2, 3'd3, 1'b1); tick();
    n_checks++; if (HMASTER !== 4'd0) $display("FAIL incr4_beat1 got %0d want 0", HMASTER); else n_pass++;
    drive(3'b101, 3'b000, 2'd3, 3'd3, 1'b1); tick();
    n_checks++; if (HMASTER !== 4'd0) $display("FAIL incr4_beat2 got %0d want 0", HMASTER); else n_pass++;
    drive(3'b101, 3'b000, 2'd3, 3'd3, 1'b0); tick(); tick();
    n_checks++; if (HMASTER !== 4'd0) $display("FAIL incr4_wait got %0d want 0", HMASTER); else n_pass++;
    drive(3'b101, 3'b000, 2'd3, 3'd3, 1'b1); tick();
    n_checks++; if (HGRANT !== 3'b001) $display("FAIL incr4_beat3 got %b want 001", HGRANT); else n_pass++;
    tick();
    n_checks++; if (HMASTER !== 4'd2) $display("FAIL incr4_beat4 got %0d want 2", HMASTER); else n_pass++;
    n_checks++; if (HGRANT !== 3'b100) $display("FAIL incr4_grant got %b want 100", HGRANT); else n_pass++;
  endtask

  task automatic test_locked();
    do_reset();
    drive(3'b010, 3'b010, 2'd0, 3'd0, 1'b1); tick();
    n_checks++; if (HMASTER !== 4'd1) $display("FAIL lock_acquire got %0d want 1", HMASTER); else n_pass++;
    n_checks++; if (HMASTLOCK !== 1'b1) $display("FAIL lock_flag got %b want 1", HMASTLOCK); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(3'b011, 3'b010, 2'd2, 3'd0, 1'b1); tick();
      n_checks++; if (HMASTER !== 4'd1) $display("FAIL lock_hold[%0d] got %0d want 1", i, HMASTER); else n_pass++;
      n_checks++; if (HMASTLOCK !== 1'b1) $display("FAIL lock_hold_flag[%0d] got %b want 1", i, HMASTLOCK); else n_pass++;
    end
    drive(3'b001, 3'b000, 2'd2, 3'd0, 1'b1); tick();
    n_checks++; if (HMASTER !== 4'd0) $display("FAIL lock_release got %0d want 0", HMASTER); else n_pass++;
    n_checks++; if (HMASTLOCK !== 1'b0) $display("FAIL lock_release_flag got %b want 0", HMASTLOCK); else n_pass++;
  endtask

  task automatic test_default_master();
    do_reset();
    drive(3'b100, 3'b000, 2'd0, 3'd0, 1'b1); tick();
    n_checks++; if (HMASTER !== 4'd2) $display("FAIL dflt_setup got %0d want 2", HMASTER); else n_pass++;
    drive(3'b000, 3'b000, 2'd0, 3'd0, 1'b1); tick();
    n_checks++; if (HGRANT !== 3'b001) $display("FAIL dflt_grant got %b want 001", HGRANT); else n_pass++;
    n_checks++; if (HMASTER_DATA !== 4'd2) $display("FAIL dflt_mdata_lag got %0d want 2", HMASTER_DATA); else n_pass++;
    drive(3'b010, 3'b000, 2'd0, 3'd0, 1'b0); tick();
    n_checks++; if (HMASTER_DATA !== 4'd2) $display("FAIL dflt_wait_mdata got %0d want 2", HMASTER_DATA); else n_pass++;
    n_checks++; if (HMASTER !== 4'd0) $display("FAIL dflt_wait_master got %0d want 0", HMASTER); else n_pass++;
    drive(3'b000, 3'b000, 2'd0, 3'd0, 1'b1); tick();
    n_checks++; if (HMASTER_DATA !== 4'd0) $display("FAIL dflt_mdata got %0d want 0", HMASTER_DATA); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(3'b010, 3'b010, 2'd0, 3'd0, 1'b1); tick();
    drive(3'b100, 3'b010, 2'd2, 3'd5, 1'b1); tick();
    drive(3'b100, 3'b010, 2'd3, 3'd5, 1'b1); tick(); tick(); tick();
    n_checks++; if (HMASTER !== 4'd1) $display("FAIL rmb_owner got %0d want 1", HMASTER); else n_pass++;
    #2 HRESET = 1'b1;
    #1;
    n_checks++; if (HGRANT !== 3'b001) $display("FAIL rmb_grant got %b want 001", HGRANT); else n_pass++;
    n_checks++; if (HMASTER !== 4'd0) $display("FAIL rmb_master got %0d want 0", HMASTER); else n_pass++;
    n_checks++; if (HMASTER_DATA !== 4'd0) $display("FAIL rmb_mdata got %0d want 0", HMASTER_DATA); else n_pass++;
    n_checks++; if (HMASTLOCK !== 1'b0) $display("FAIL rmb_mastlock got %b want 0", HMASTLOCK); else n_pass++;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    model_reset();
    drive(3'b100, 3'b000, 2'd3, 3'd5, 1'b1); tick();
    n_checks++; if (HMASTER !== 4'd2) $display("FAIL rmb_cnt_cleared got %0d want 2", HMASTER); else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] g;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0));
      tick();
      g = 3'b001 << m_owner;
      n_checks++; if (HGRANT !== g) $display("FAIL rnd_grant[%0d] got %b want %b", i, HGRANT, g); else n_pass++;
      n_checks++; if (HMASTER !== 4'(m_owner)) $display("FAIL rnd_master[%0d] got %0d want %0d", i, HMASTER, m_owner); else n_pass++;
      n_checks++; if (HMASTER_DATA !== 4'(m_data)) $display("FAIL rnd_mdata[%0d] got %0d want %0d", i, HMASTER_DATA, m_data); else n_pass++;
      n_checks++; if (HMASTLOCK !== m_lock) $display("FAIL rnd_mastlock[%0d] got %b want %b", i, HMASTLOCK, m_lock); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_incr4_hold();
    test_locked();
    test_default_master();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
